wave_bank_scheduler: RTL and testbench
======================================

WAVE_BANK_SCHEDULER -- requirements
Module: wave_bank_scheduler

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive write grants while a read is pending.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 wr_req  input  1  capture write request; one sample per cycle when high.
REQ-005 wr_addr  input  8  capture sample index, 0-255.
REQ-006 wr_data  input  8  offset-binary sample to store.
REQ-007 rd_req  input  1  display read request.
REQ-008 rd_addr  input  8  display sample index, 0-255.
REQ-009 frame_start  input  1  one-cycle pulse at the display vertical blank.
REQ-010 ram_rdata  input  8  RAM read data, valid one cycle after a read is issued.
REQ-011 ram_addr  output  9  {bank, index} to the shared single-port 512x8 RAM.
REQ-012 ram_we  output  1  RAM write strobe.
REQ-013 ram_wdata  output  8  RAM write data.
REQ-014 rd_data  output  8  read data returned to the display.
REQ-015 rd_valid  output  1  high for exactly the one cycle in which rd_data is valid.
REQ-016 rd_stall  output  1  rd_req was not granted this cycle; the display holds rd_addr.
REQ-017 cap_arm  output  1  capture may arm; high only in FILL.
REQ-018 read_bank  output  1  bank the display reads; the write bank is ~read_bank.
REQ-019 swap_pulse  output  1  one-cycle pulse when the banks swap.
REQ-020 wr_drop  output  1  sticky flag: a write was lost.

Function
REQ-021 FSM states: FILL, FULL, SWAP. Reset state is FILL.
REQ-022 FILL -> FULL on the cycle in which the 256th accepted write issues to RAM (write counter goes 255 -> 0).
REQ-023 FULL -> SWAP when frame_start = 1; otherwise stay in FULL.
REQ-024 SWAP lasts exactly 1 cycle, then returns to FILL.
REQ-025 In SWAP, read_bank toggles on the exiting edge, and swap_pulse = 1 during the SWAP cycle.
REQ-026 A frame_start arriving in FILL or SWAP is ignored; it is not remembered.
REQ-027 One-deep write holding register (hold_valid, hold_addr, hold_data):
- A wr_req in FILL loads it when it is empty or being drained in the same cycle.
- A wr_req in FULL or SWAP is discarded and sets wr_drop.
- A wr_req while the register is full and not draining sets wr_drop; the new write is lost and the held write is kept.
REQ-028 Arbitration, evaluated combinationally each cycle:
- If hold_valid and the starvation counter < STARVE_LIMIT, the write is granted.
- Otherwise, if rd_req, the read is granted.
- Otherwise, a valid held write is granted.
REQ-029 Starvation counter: +1 on each write grant while rd_req = 1; cleared on any read grant or when rd_req = 0; saturates at STARVE_LIMIT.
REQ-030 Write grant drives ram_we = 1, ram_addr = {~read_bank, hold_addr}, ram_wdata = hold_data; it clears hold_valid and increments the 8-bit write counter, which wraps.
REQ-031 Read grant drives ram_we = 0, ram_addr = {read_bank, rd_addr}, rd_stall = 0.
REQ-032 On a read grant, rd_valid = 1 on the next cycle and rd_data = ram_rdata (combinational pass in that cycle).
REQ-033 rd_stall = rd_req & ~read_grant.
REQ-034 When no request is granted: ram_we = 0, ram_addr = {read_bank, 8'h00}, ram_wdata = 0.
REQ-035 Write-to-RAM latency is 1 cycle from wr_req: it registers into hold, then issues on the next cycle if granted.
REQ-036 A read at a given address always targets read_bank. The bank being written is never visible to the display until the swap.
REQ-037 wr_drop is cleared only by reset.
REQ-038 The write counter is cleared on entry to FILL.
REQ-039 The write counter counts grants, not wr_addr values; wr_addr is used only as the RAM index.

Reset
REQ-040 Reset values:
- State FILL; read_bank = 0; write counter = 0; starvation counter = 0.
- hold_valid = 0; wr_drop = 0.
- rd_valid = 0; swap_pulse = 0; ram_we = 0; cap_arm = 1 once the state is FILL.
REQ-041 Reset asserted mid-read discards the pending rd_valid.
REQ-042 Reset asserted mid-fill discards the partial capture; no swap occurs.

Verification
REQ-043 Fill and swap:
- Stimulus: 256 writes, data = index, with no reads; then a frame_start pulse.
- Response: FULL after the 256th write; swap_pulse exactly one cycle after frame_start; read_bank goes 0 -> 1.
- Then reading address 0x10 returns 0x10.
REQ-044 Starvation guard: rd_req held high with back-to-back writes at STARVE_LIMIT = 4 -> the read is granted after 4 write grants; rd_valid follows 1 cycle later.
REQ-045 Dropped writes: a wr_req during FULL -> no RAM write occurs, wr_drop = 1, and wr_drop stays 1 until reset.
REQ-046 Ignored frame_start: frame_start during FILL at write 100 -> no swap; read_bank stays 0; the swap occurs only at the next frame_start after FULL.
REQ-047 Async reset mid-read: reset asserted between a read grant and its rd_valid -> rd_valid stays 0; outputs are at reset values without waiting for a clk edge.
REQ-048 Bank isolation: during FILL, reading any address returns the previous capture and never data written in the current fill.

Source files
------------

// File: rtl/wave_bank_scheduler.sv
// Double-buffered waveform capture scheduler: one bank fills while the display
// reads the other, sharing a single-port RAM; banks swap at vertical blank.
module wave_bank_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    input  logic       frame_start,
    input  logic [7:0] ram_rdata,
    output logic [8:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rd_stall,
    output logic       cap_arm,
    output logic       read_bank,
    output logic       swap_pulse,
    output logic       wr_drop
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {FILL, FULL, SWAP} state_t;

    state_t        state_q, state_d;
    logic          hold_valid_q, hold_valid_d;
    logic [7:0]    hold_addr_q, hold_addr_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic [7:0]    wr_cnt_q, wr_cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          read_bank_q, read_bank_d;
    logic          wr_drop_q, wr_drop_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_grant, rd_grant;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        wr_cnt_d     = wr_cnt_q;
        starve_d     = starve_q;
        read_bank_d  = read_bank_q;
        wr_drop_d    = wr_drop_q;
        ram_we       = 1'b0;
        ram_addr     = {read_bank_q, 8'h00};
        ram_wdata    = 8'h00;

        // A held write wins unless it has already starved a pending read.
        wr_grant   = hold_valid_q && ((starve_q < LIMIT) || !rd_req);
        rd_grant   = rd_req && !wr_grant;
        rd_valid_d = rd_grant;

        if (wr_grant) begin
            ram_we       = 1'b1;
            ram_addr     = {~read_bank_q, hold_addr_q};
            ram_wdata    = hold_data_q;
            hold_valid_d = 1'b0;
            wr_cnt_d     = wr_cnt_q + 8'd1;
        end else if (rd_grant) begin
            ram_addr = {read_bank_q, rd_addr};
        end

        if (!rd_req || rd_grant) begin
            starve_d = '0;
        end else if (wr_grant && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end

        if (wr_req) begin
            if ((state_q == FILL) && (!hold_valid_q || wr_grant)) begin
                hold_valid_d = 1'b1;
                hold_addr_d  = wr_addr;
                hold_data_d  = wr_data;
            end else begin
                wr_drop_d = 1'b1;
            end
        end

        case (state_q)
            FILL: if (wr_grant && (wr_cnt_q == 8'hFF)) state_d = FULL;
            FULL: if (frame_start) state_d = SWAP;
            SWAP: begin
                state_d     = FILL;
                read_bank_d = ~read_bank_q;
                wr_cnt_d    = 8'h00;
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= 8'h00;
            hold_data_q  <= 8'h00;
            wr_cnt_q     <= 8'h00;
            starve_q     <= '0;
            read_bank_q  <= 1'b0;
            wr_drop_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            wr_cnt_q     <= wr_cnt_d;
            starve_q     <= starve_d;
            read_bank_q  <= read_bank_d;
            wr_drop_q    <= wr_drop_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign rd_data    = ram_rdata;
    assign rd_valid   = rd_valid_q;
    assign rd_stall   = rd_req & ~rd_grant;
    assign cap_arm    = (state_q == FILL);
    assign swap_pulse = (state_q == SWAP);
    assign read_bank  = read_bank_q;
    assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_wave_bank_scheduler.sv
// Directed bench for wave_bank_scheduler with a behavioural 512x8 synchronous
// RAM; inputs change on the falling edge, outputs are checked mid-cycle.
module tb_wave_bank_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req, rd_req, frame_start;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] ram_rdata;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata, rd_data;
    logic       rd_valid, rd_stall, cap_arm, read_bank, swap_pulse, wr_drop;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [512];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    wave_bank_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .frame_start(frame_start),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_stall(rd_stall), .cap_arm(cap_arm), .read_bank(read_bank),
        .swap_pulse(swap_pulse), .wr_drop(wr_drop)
    );

    // Back-to-back writes of data = addr ^ xr; returns inside the cycle in
    // which the last write issues to RAM.
    task automatic write_burst(input int n, input int first, input logic [7:0] xr, input int fs_at);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a           = 8'(first + i);
            wr_req      = 1'b1;
            wr_addr     = a;
            wr_data     = a ^ xr;
            frame_start = (i == fs_at);
            #1;
            if (i == fs_at + 1) begin
                n_cmp++;
                if (swap_pulse !== 1'b0 || cap_arm !== 1'b1) begin
                    n_bad++;
                    $display("FAIL fill_frame_start_ignored: swap_pulse=%b cap_arm=%b want 0/1", swap_pulse, cap_arm);
                end
            end
        end
        @(negedge clk);
        wr_req      = 1'b0;
        frame_start = 1'b0;
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic bank, input logic [7:0] exp);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = a;
        #1;
        n_cmp++;
        if (ram_addr !== {bank, a} || ram_we !== 1'b0 || rd_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL read_issue_%h: ram_addr=%h we=%b stall=%b want %h/0/0", a, ram_addr, ram_we, rd_stall, {bank, a});
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            n_bad++;
            $display("FAIL read_data_%h: rd_valid=%b rd_data=%h want 1/%h", a, rd_valid, rd_data, exp);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL read_valid_one_cycle_%h: rd_valid=%b want 0", a, rd_valid);
        end
    endtask

    task automatic swap_sequence(input logic bank_before);
        @(negedge clk);
        frame_start = 1'b1;
        #1;
        n_cmp++;
        if (swap_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL swap_early: swap_pulse=%b want 0", swap_pulse);
        end
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        n_cmp++;
        if (swap_pulse !== 1'b1 || read_bank !== bank_before || cap_arm !== 1'b0) begin
            n_bad++;
            $display("FAIL swap_cycle: swap_pulse=%b read_bank=%b cap_arm=%b want 1/%b/0", swap_pulse, read_bank, cap_arm, bank_before);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (swap_pulse !== 1'b0 || read_bank !== ~bank_before || cap_arm !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_after: swap_pulse=%b read_bank=%b cap_arm=%b want 0/%b/1", swap_pulse, read_bank, cap_arm, ~bank_before);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_req = 0; rd_req = 0; frame_start = 0;
        wr_addr = 0; wr_data = 0; rd_addr = 0;
        #12;
        n_cmp++;
        if (cap_arm !== 1'b1 || read_bank !== 1'b0 || swap_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: cap_arm=%b read_bank=%b swap_pulse=%b want 1/0/0", cap_arm, read_bank, swap_pulse);
        end
        n_cmp++;
        if (ram_we !== 1'b0 || rd_valid !== 1'b0 || wr_drop !== 1'b0 || rd_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: we=%b rd_valid=%b wr_drop=%b stall=%b want 0/0/0/0", ram_we, rd_valid, wr_drop, rd_stall);
        end
        n_cmp++;
        if (ram_addr !== 9'h000 || ram_wdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ram_bus: ram_addr=%h ram_wdata=%h want 000/00", ram_addr, ram_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_swap();
        write_burst(256, 0, 8'h00, 100);
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 9'h1FF || ram_wdata !== 8'hFF || cap_arm !== 1'b1) begin
            n_bad++;
            $display("FAIL last_write: we=%b addr=%h wdata=%h cap_arm=%b want 1/1ff/ff/1", ram_we, ram_addr, ram_wdata, cap_arm);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (cap_arm !== 1'b0 || read_bank !== 1'b0 || swap_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL full_state: cap_arm=%b read_bank=%b swap_pulse=%b want 0/0/0", cap_arm, read_bank, swap_pulse);
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (swap_pulse !== 1'b0 || cap_arm !== 1'b0) begin
            n_bad++;
            $display("FAIL full_holds: swap_pulse=%b cap_arm=%b want 0/0", swap_pulse, cap_arm);
        end
        swap_sequence(1'b0);
        do_read(8'h10, 1'b1, 8'h10);
        do_read(8'hC3, 1'b1, 8'hC3);
    endtask

    task automatic test_bank_isolation();
        write_burst(1, 8'h10, 8'hBA, -1);
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 9'h010 || ram_wdata !== 8'hAA) begin
            n_bad++;
            $display("FAIL iso_write: we=%b addr=%h wdata=%h want 1/010/aa", ram_we, ram_addr, ram_wdata);
        end
        do_read(8'h10, 1'b1, 8'h10);
    endtask

    task automatic test_starvation();
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 8'h20; wr_data = 8'h50; rd_req = 1'b0;
        #1;
        n_cmp++;
        if (ram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL starve_load: we=%b want 0", ram_we);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            wr_addr = 8'(8'h20 + k); wr_data = 8'(8'h50 + k);
            rd_req = 1'b1; rd_addr = 8'h10;
            #1;
            n_cmp++;
            if (ram_we !== 1'b1 || rd_stall !== 1'b1 || ram_addr !== {1'b0, 8'(8'h20 + k - 1)}) begin
                n_bad++;
                $display("FAIL starve_wgrant_%0d: we=%b stall=%b addr=%h want 1/1/%h", k, ram_we, rd_stall, ram_addr, {1'b0, 8'(8'h20 + k - 1)});
            end
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        n_cmp++;
        if (ram_we !== 1'b0 || rd_stall !== 1'b0 || ram_addr !== 9'h110) begin
            n_bad++;
            $display("FAIL starve_rgrant: we=%b stall=%b addr=%h want 0/0/110", ram_we, rd_stall, ram_addr);
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h10 || ram_we !== 1'b1 || ram_addr !== 9'h024) begin
            n_bad++;
            $display("FAIL starve_after: rd_valid=%b rd_data=%h we=%b addr=%h want 1/10/1/024", rd_valid, rd_data, ram_we, ram_addr);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (ram_we !== 1'b0 || wr_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL starve_idle: we=%b wr_drop=%b want 0/0", ram_we, wr_drop);
        end
    endtask

    task automatic test_drop();
        write_burst(250, 6, 8'hFF, -1);
        n_cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 9'h0FF || cap_arm !== 1'b1) begin
            n_bad++;
            $display("FAIL refill_last: we=%b addr=%h cap_arm=%b want 1/0ff/1", ram_we, ram_addr, cap_arm);
        end
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 8'h33; wr_data = 8'h77;
        #1;
        n_cmp++;
        if (cap_arm !== 1'b0 || ram_we !== 1'b0 || wr_drop !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_cycle: cap_arm=%b we=%b wr_drop=%b want 0/0/0", cap_arm, ram_we, wr_drop);
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        n_cmp++;
        if (wr_drop !== 1'b1 || ram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_flag: wr_drop=%b we=%b want 1/0", wr_drop, ram_we);
        end
        swap_sequence(1'b1);
        n_cmp++;
        if (wr_drop !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_sticky: wr_drop=%b want 1", wr_drop);
        end
        do_read(8'h10, 1'b0, 8'hEF);
        do_read(8'h33, 1'b0, 8'hCC);
        do_read(8'h22, 1'b0, 8'hDD);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 8'h10;
        #1;
        n_cmp++;
        if (ram_addr !== 9'h010 || rd_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_read_issue: addr=%h stall=%b want 010/0", ram_addr, rd_stall);
        end
        #1;
        reset = 1'b1; rd_req = 1'b0;
        #1;
        n_cmp++;
        if (wr_drop !== 1'b0 || rd_valid !== 1'b0 || cap_arm !== 1'b1 || ram_addr !== 9'h000) begin
            n_bad++;
            $display("FAIL rst_async: wr_drop=%b rd_valid=%b cap_arm=%b addr=%h want 0/0/1/000", wr_drop, rd_valid, cap_arm, ram_addr);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rd_valid !== 1'b0 || read_bank !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_valid: rd_valid=%b read_bank=%b want 0/0", rd_valid, read_bank);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        write_burst(10, 0, 8'h5A, -1);
        #1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        n_cmp++;
        if (swap_pulse !== 1'b0 || cap_arm !== 1'b1 || read_bank !== 1'b0 || ram_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_fill_no_swap: swap_pulse=%b cap_arm=%b read_bank=%b we=%b want 0/1/0/0", swap_pulse, cap_arm, read_bank, ram_we);
        end
    endtask

    initial begin
        test_reset();
        test_fill_swap();
        test_bank_isolation();
        test_starvation();
        test_drop();
        test_reset_mid_read();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
